tdm_scan_ctrl: RTL and testbench
================================

// Module: tdm_scan_ctrl
// PURPOSE
//   Select-line sequencer that sits directly upstream of the 4:1 mux and consumes its output.
//   Drives the 2-bit mux select round-robin over the enabled channels, holding each one for a
//   programmable settle (dwell) time. Samples mux_y into a 4-bit frame register and reports
//   per-channel samples and a completed frame.
// PARAMETERS
//   NUM_CH   4   channels scanned (fixed to mux width; SEL_W = clog2(NUM_CH))
//   SEL_W    2   select width
//   DWELL_W  8   width of dwell-count input
// PORTS
//   clk           in   1        rising-edge clock
//   rst_n         in   1        asynchronous active-low reset
//   start         in   1        1-cycle pulse; begins continuous scanning (ignored while busy)
//   stop          in   1        1-cycle pulse; finish current frame, then go idle
//   dwell         in   DWELL_W  settle cycles per channel before sampling (0 treated as 1)
//   ch_mask       in   NUM_CH   channel enable mask (present only with TDM_SCAN_MASK_EN)
//   mux_y         in   1        output of the downstream 4:1 mux
//   sel           out  SEL_W    mux select
//   busy          out  1        high from cycle after accepted start until idle
//   sample_valid  out  1        1-cycle pulse: sample_ch/sample_bit valid
//   sample_ch     out  SEL_W    channel just sampled
//   sample_bit    out  1        mux_y captured for sample_ch
//   frame         out  NUM_CH   last completed frame; bit i = channel i (masked bits = 0)
//   frame_valid   out  1        1-cycle pulse: frame updated
// BEHAVIOUR
//   Reset: all outputs 0, sel=0, FSM=IDLE. Applies asynchronously at any point, mid-frame included.
//   FSM: IDLE -> DWELL -> SAMPLE -> (DWELL next ch | IDLE). All outputs are registered.
//   IDLE: start with effective mask != 0 -> DWELL. In the same edge, latch mask and D=max(dwell,1),
//     set sel=lowest enabled ch, and set busy=1. Start with mask == 0 is ignored.
//   DWELL: sel held; count D cycles -> SAMPLE.
//   SAMPLE (1 cycle): capture mux_y into frame_shadow[sel]. Next cycle: sample_valid=1,
//     sample_ch=sel of the SAMPLE cycle, sample_bit=captured value.
//   Each channel therefore holds sel for D+1 cycles.
//   Advance: the next enabled ch above the current one, wrapping. Leaving the highest enabled ch
//     completes the frame. On completion, frame<=frame_shadow (masked bits 0) and frame_valid
//     pulses in the same cycle as that last sample_valid. frame_shadow is then cleared.
//   Mask and D are re-latched only at frame boundaries. Mid-frame input changes have no effect.
//   stop: sets a pending flag. At frame completion with pending set -> IDLE, busy=0 from the
//     cycle after frame_valid, sel keeps its last value. stop and start together in IDLE: start
//     is accepted and stop is pended.
//   start while busy: ignored. Single enabled channel: the frame completes every D+1 cycles.
// CONFIGURATION
//   TDM_SCAN_MASK_EN defined: ch_mask port exists, disabled channels are skipped and read as 0.
//   Not defined: no ch_mask port; effective mask = all ones, all NUM_CH channels are scanned.
// STRUCTURE
//   tdm_scan_pkg: state enum {IDLE,DWELL,SAMPLE}, NUM_CH, SEL_W constants.
//   Sub-module tdm_next_ch: combinational next-enabled-channel finder. Inputs: mask, cur.
//     Outputs: nxt, wrap, first (lowest enabled).
//   Top: FSM, dwell counter, frame_shadow/frame regs, output regs.
// TESTING (bench models the mux: mux_y = d[sel])
//   1. mask=1111, dwell=2, d=1010, start -> sel 0,1,2,3 each held 3 cycles; sample_bits 0,1,0,1;
//      frame=1010 with frame_valid 13 cycles after the start edge.
//   2. mask=0101, dwell=1, d=1111 -> sel visits only 0,2 (2 cycles each); frame=0101.
//   3. dwell=0 -> identical timing to dwell=1.
//   4. stop mid-frame in test 1 -> frame completes (frame_valid); busy=0 the next cycle;
//      no further sample_valid.
//   5. rst_n low during DWELL -> sel, busy, frame, and the valids go 0 immediately (async),
//      FSM=IDLE; restart works.
//   6. mask=0000 + start -> busy stays 0, no pulses. Without TDM_SCAN_MASK_EN, all 4 channels
//      are scanned.

Source files
------------

// File: rtl/tdm_scan_pkg.sv
// Shared constants and FSM state encoding for the TDM select-line scanner.
package tdm_scan_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DWELL  = 2'd1,
        SAMPLE = 2'd2
    } state_e;
endpackage

// File: rtl/tdm_scan_ctrl_next_ch.sv
// Combinational channel finder: lowest enabled channel, and next enabled channel above cur.
module tdm_next_ch
    import tdm_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  nxt,
    output logic              wrap,
    output logic [SEL_W-1:0]  first
);
    // Scanning downward leaves the lowest qualifying index as the winner.
    always_comb begin
        first = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) first = SEL_W'(i);
        end
        nxt  = first;
        wrap = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                nxt  = SEL_W'(i);
                wrap = 1'b0;
            end
        end
    end
endmodule

// File: rtl/tdm_scan_ctrl.sv
// Round-robin mux select sequencer with per-channel dwell and frame capture.
// Optional channel masking is enabled by defining TDM_SCAN_MASK_EN.
module tdm_scan_ctrl
    import tdm_scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
`ifdef TDM_SCAN_MASK_EN
    input  logic [NUM_CH-1:0]  ch_mask,
`endif
    input  logic               mux_y,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               sample_valid,
    output logic [SEL_W-1:0]   sample_ch,
    output logic               sample_bit,
    output logic [NUM_CH-1:0]  frame,
    output logic               frame_valid
);
    logic [NUM_CH-1:0]  mask_eff;
    logic [DWELL_W-1:0] dwell_eff;

`ifdef TDM_SCAN_MASK_EN
    assign mask_eff = ch_mask;
`else
    assign mask_eff = '1;
`endif
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    state_e             state_q;
    logic [NUM_CH-1:0]  mask_q;
    logic [DWELL_W-1:0] dlen_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [NUM_CH-1:0]  shadow_q;
    logic [NUM_CH-1:0]  shadow_d;
    logic [NUM_CH-1:0]  frame_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sample_ch_q;
    logic               busy_q;
    logic               stop_pend_q;
    logic               sample_valid_q;
    logic               sample_bit_q;
    logic               frame_valid_q;

    logic [SEL_W-1:0]   adv_nxt;
    logic               adv_wrap;
    logic [SEL_W-1:0]   adv_first;
    logic [SEL_W-1:0]   new_first;
    logic [SEL_W-1:0]   new_nxt;
    logic               new_wrap;

    // Advance within the latched frame mask.
    tdm_next_ch u_adv (
        .mask  (mask_q),
        .cur   (sel_q),
        .nxt   (adv_nxt),
        .wrap  (adv_wrap),
        .first (adv_first)
    );

    // First channel of the live mask, used when a new frame is latched.
    tdm_next_ch u_first (
        .mask  (mask_eff),
        .cur   ('0),
        .nxt   (new_nxt),
        .wrap  (new_wrap),
        .first (new_first)
    );

    logic unused_ok;
    assign unused_ok = ^{adv_first, new_nxt, new_wrap};

    always_comb begin
        shadow_d        = shadow_q;
        shadow_d[sel_q] = mux_y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mask_q         <= '0;
            dlen_q         <= '0;
            cnt_q          <= '0;
            shadow_q       <= '0;
            frame_q        <= '0;
            sel_q          <= '0;
            sample_ch_q    <= '0;
            busy_q         <= 1'b0;
            stop_pend_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_bit_q   <= 1'b0;
            frame_valid_q  <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            frame_valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // busy lingers one cycle after a stop so it drops after frame_valid
                    busy_q <= 1'b0;
                    if (start && !busy_q && (mask_eff != '0)) begin
                        state_q     <= DWELL;
                        mask_q      <= mask_eff;
                        dlen_q      <= dwell_eff;
                        cnt_q       <= DWELL_W'(1);
                        sel_q       <= new_first;
                        busy_q      <= 1'b1;
                        stop_pend_q <= stop;
                    end
                end
                DWELL: begin
                    if (stop) stop_pend_q <= 1'b1;
                    if (cnt_q == dlen_q) state_q <= SAMPLE;
                    else                 cnt_q   <= cnt_q + DWELL_W'(1);
                end
                SAMPLE: begin
                    sample_valid_q <= 1'b1;
                    sample_ch_q    <= sel_q;
                    sample_bit_q   <= mux_y;
                    cnt_q          <= DWELL_W'(1);
                    if (adv_wrap) begin
                        frame_q       <= shadow_d & mask_q;
                        frame_valid_q <= 1'b1;
                        shadow_q      <= '0;
                        if (stop_pend_q || stop || (mask_eff == '0)) begin
                            state_q     <= IDLE;
                            stop_pend_q <= 1'b0;
                        end else begin
                            state_q <= DWELL;
                            mask_q  <= mask_eff;
                            dlen_q  <= dwell_eff;
                            sel_q   <= new_first;
                        end
                    end else begin
                        if (stop) stop_pend_q <= 1'b1;
                        shadow_q <= shadow_d;
                        sel_q    <= adv_nxt;
                        state_q  <= DWELL;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel          = sel_q;
    assign busy         = busy_q;
    assign sample_valid = sample_valid_q;
    assign sample_ch    = sample_ch_q;
    assign sample_bit   = sample_bit_q;
    assign frame        = frame_q;
    assign frame_valid  = frame_valid_q;
endmodule

// File: tb/tb_tdm_scan_ctrl.sv
// Directed bench for tdm_scan_ctrl; models the downstream mux as mux_y = d[sel].
module tb_tdm_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [3:0] ch_mask = 4'd0;
    logic [3:0] d = 4'd0;
    logic       mux_y;
    logic [1:0] sel;
    logic       busy;
    logic       sample_valid;
    logic [1:0] sample_ch;
    logic       sample_bit;
    logic [3:0] frame;
    logic       frame_valid;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;
    assign mux_y = d[sel];

    tdm_scan_ctrl #(.DWELL_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .dwell        (dwell),
`ifdef TDM_SCAN_MASK_EN
        .ch_mask      (ch_mask),
`endif
        .mux_y        (mux_y),
        .sel          (sel),
        .busy         (busy),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_bit   (sample_bit),
        .frame        (frame),
        .frame_valid  (frame_valid)
    );

    typedef struct {
        logic [3:0]      mask;
        logic [7:0]      dwell;
        logic [3:0]      d;
        logic [3:0]      exp_frame;
        int              exp_fv;     // edge count (start edge = 1) carrying frame_valid
        int              exp_hold;   // cycles sel stays on each channel
        int              exp_n;      // samples per frame
        logic [3:0][1:0] exp_chs;    // channel visit order, [0] first
        logic [3:0]      exp_bits;   // bit j = j-th sample_bit
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] m, logic [7:0] dw, logic [3:0] dd, logic [3:0] fr,
                                int fv, int hold, int n, logic [7:0] chs, logic [3:0] bits);
        vec_t v;
        v.mask = m; v.dwell = dw; v.d = dd; v.exp_frame = fr; v.exp_fv = fv;
        v.exp_hold = hold; v.exp_n = n; v.exp_chs = chs; v.exp_bits = bits;
        return v;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    // Start with stop pended so exactly one frame runs, then check every cycle.
    task automatic run_vec(input vec_t v);
        int idx;
        logic sv_exp;
        ch_mask = v.mask; dwell = v.dwell; d = v.d;
        start = 1'b1; stop = 1'b1;
        for (int k = 1; k <= v.exp_fv + 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin start = 1'b0; stop = 1'b0; end
            idx = (k <= v.exp_n * v.exp_hold) ? (k - 1) / v.exp_hold : v.exp_n - 1;
            chk("sel", k, sel, v.exp_chs[idx]);
            chk("busy", k, busy, (k <= v.exp_fv));
            sv_exp = (k > 1) && ((k - 1) % v.exp_hold == 0) && ((k - 1) / v.exp_hold <= v.exp_n);
            chk("sample_valid", k, sample_valid, sv_exp);
            if (sv_exp) begin
                idx = (k - 1) / v.exp_hold - 1;
                chk("sample_ch", k, sample_ch, v.exp_chs[idx]);
                chk("sample_bit", k, sample_bit, v.exp_bits[idx]);
            end
            chk("frame_valid", k, frame_valid, (k == v.exp_fv));
            if (k == v.exp_fv) chk("frame", k, frame, v.exp_frame);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        tbl.push_back(mk(4'b1111, 8'd2, 4'b1010, 4'b1010, 13, 3, 4, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b1010));
        tbl.push_back(mk(4'b1111, 8'd1, 4'b0110, 4'b0110,  9, 2, 4, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0110));
        tbl.push_back(mk(4'b1111, 8'd0, 4'b0110, 4'b0110,  9, 2, 4, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0110));
        tbl.push_back(mk(4'b1111, 8'd5, 4'b1111, 4'b1111, 25, 6, 4, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b1111));
`ifdef TDM_SCAN_MASK_EN
        tbl.push_back(mk(4'b0101, 8'd1, 4'b1111, 4'b0101,  5, 2, 2, {2'd0, 2'd0, 2'd2, 2'd0}, 4'b0011));
        tbl.push_back(mk(4'b1000, 8'd2, 4'b1000, 4'b1000,  4, 3, 1, {2'd0, 2'd0, 2'd0, 2'd3}, 4'b0001));
        tbl.push_back(mk(4'b0110, 8'd0, 4'b0011, 4'b0010,  5, 2, 2, {2'd0, 2'd0, 2'd2, 2'd1}, 4'b0001));
`else
        // Without masking a zero mask input still scans all four channels.
        tbl.push_back(mk(4'b0000, 8'd1, 4'b1001, 4'b1001,  9, 2, 4, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b1001));
`endif

        #1;
        chk("rst_sel", 0, sel, 0);
        chk("rst_busy", 0, busy, 0);
        chk("rst_frame", 0, frame, 0);
        chk("rst_valids", 0, {sample_valid, frame_valid}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // Mid-frame stop, start-while-busy and dwell change all leave frame 1 untouched.
        ch_mask = 4'b1111; dwell = 8'd2; d = 4'b1010; start = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (k == 4) begin start = 1'b1; dwell = 8'd7; end
            if (k == 5) start = 1'b0;
            if (k == 6) stop = 1'b1;
            if (k == 7) stop = 1'b0;
            chk("stop_busy", k, busy, (k <= 13));
            chk("stop_sv", k, sample_valid, (k == 4 || k == 7 || k == 10 || k == 13));
            if (sample_valid) chk("stop_sch", k, sample_ch, (k - 4) / 3);
            chk("stop_fv", k, frame_valid, (k == 13));
            if (k == 13) chk("stop_frame", k, frame, 4'b1010);
        end
        dwell = 8'd1;

        // Continuous scan: dwell re-latched at the frame boundary, new data in frame 2.
        d = 4'b0110; start = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (k == 3) dwell = 8'd2;
            chk("cont_fv", k, frame_valid, (k == 9 || k == 21));
            if (k == 9) begin chk("cont_frame1", k, frame, 4'b0110); d = 4'b1001; end
            if (k == 15) stop = 1'b1;
            if (k == 16) stop = 1'b0;
            if (k == 21) chk("cont_frame2", k, frame, 4'b1001);
            chk("cont_busy", k, busy, (k <= 21));
        end

        // Asynchronous reset mid-frame, then a clean restart.
        dwell = 8'd1; d = 4'b1111; start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (k == 9) chk("pre_rst_frame", k, frame, 4'b1111);
        end
        chk("pre_rst_sv", 11, sample_valid, 1);
        chk("pre_rst_sel", 11, sel, 1);
        rst_n = 1'b0; #1;
        chk("arst_sel", 11, sel, 0);
        chk("arst_busy", 11, busy, 0);
        chk("arst_frame", 11, frame, 0);
        chk("arst_valids", 11, {sample_valid, frame_valid}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(tbl[0]);

`ifdef TDM_SCAN_MASK_EN
        // An all-zero mask makes start a no-op.
        ch_mask = 4'b0000; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            chk("zmask_busy", k, busy, 0);
            chk("zmask_pulses", k, {sample_valid, frame_valid}, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
